adder_nbit_serial: RTL
======================

// Module: adder_nbit_serial
// PURPOSE
//  Parametrised, multi-cycle ripple adder/subtractor. Processes CHUNK bits per clock, LSB chunk first.
//  Wide adds trade latency for area.
//  Operands come in on a valid/ready handshake; the result goes out on another.
//  Intended as the general-width replacement for fixed-width combinational adders in datapaths.
// PARAMETERS
//  WIDTH  16  operand/result width in bits; must be a multiple of CHUNK
//  CHUNK   4  bits added per cycle; 1 <= CHUNK <= WIDTH; NCHUNK = WIDTH/CHUNK
// PORTS
//  clk_i    in   1      clock, rising edge
//  rst_n_i  in   1      reset, asynchronous, active-low
//  A_i      in   WIDTH  operand A
//  B_i      in   WIDTH  operand B
//  C_i      in   1      carry-in (add) / borrow-in (sub)
//  sub_i    in   1      0: add, 1: subtract
//  valid_i  in   1      operands valid
//  ready_o  out  1      block can accept operands
//  S_o      out  WIDTH  sum/difference (registered)
//  C_o      out  1      raw carry-out of MSB; in sub mode 1 = no borrow
//  ovf_o    out  1      two's-complement signed overflow
//  valid_o  out  1      result valid
//  ready_i  in   1      downstream accepts result
// BEHAVIOUR
//  - Clock and reset: one clock, clk_i; rst_n_i is asynchronous, active-low.
//  - Reset (rst_n_i=0, any time, incl. mid-operation):
//    - state=IDLE, any operation in flight is abandoned.
//    - S_o=0, C_o=0, ovf_o=0, valid_o=0.
//    - ready_o=1 (decoded from IDLE).
//  - FSM: IDLE -> CALC -> DONE -> IDLE.
//  - IDLE:
//    - ready_o=1.
//    - On valid_i&ready_o, latch A, b and carry, clear chunk index k=0, go to CALC.
//    - b = sub_i ? ~B_i : B_i.
//    - carry = sub_i ? ~C_i : C_i.
//  - CALC:
//    - ready_o=0, valid_o=0.
//    - Each cycle: {carry, S[k*CHUNK +: CHUNK]} = A_chunk + b_chunk + carry; k++.
//    - On the cycle computing chunk NCHUNK-1, also record the carry into the MSB, then go to DONE.
//  - Latency: operands accepted at edge T; valid_o rises after edge T+NCHUNK. CHUNK=WIDTH gives 1 cycle.
//  - DONE:
//    - valid_o=1.
//    - S_o, C_o and ovf_o are stable and held while ready_i=0.
//    - On ready_i=1 at an edge, go to IDLE with valid_o=0.
//    - No same-cycle re-accept: the next operand is accepted no earlier than the cycle after the result handshake.
//  - Output values: ovf_o = carry_into_MSB ^ C_o.
//  - Results hold: S_o/C_o/ovf_o keep their last value until the next DONE. Only valid_o qualifies them.
//  - Ignored inputs: valid_i while not IDLE is ignored (no queuing). Operand inputs are sampled only at accept.
//  - Width rules:
//    - Results wrap modulo 2^WIDTH.
//    - Sub computes A - B - C_i as A + ~B + ~C_i.
//  - Simultaneous valid_i in the DONE->IDLE cycle is not accepted.
// TESTING (WIDTH=16, CHUNK=4 unless noted; every result checked at valid_o, with latency = 4 cycles)
//  1. add 0x000A+0x0005, C_i=0 -> S_o=0x000F, C_o=0, ovf_o=0, valid_o high 4 edges after accept
//  2. add 0xFFFF+0x0001, C_i=0 -> S_o=0x0000, C_o=1, ovf_o=0 (full carry ripple across all chunks)
//  3. add 0x7FFF+0x0001, C_i=0 -> S_o=0x8000, C_o=0, ovf_o=1
//  4. sub 0x0003-0x0007, C_i=0 -> S_o=0xFFFC, C_o=0 (borrow), ovf_o=0
//  5. hold ready_i=0 for 5 cycles in DONE, pulse valid_i -> valid_o/S_o stable, ready_o=0, pulse ignored
//  6. assert rst_n_i=0 during CALC k=2 -> outputs 0, ready_o=1, no valid_o; re-run case 1 passes; repeat case 2 with CHUNK=16 -> latency 1

Source files
------------

// File: rtl/adder_nbit_serial.sv
// Multi-cycle ripple adder/subtractor.
// Adds CHUNK bits per clock, starting with the least significant chunk.
// Operands arrive on a valid/ready handshake and the result leaves on a second one.
module adder_nbit_serial #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  input  logic             C_i,
  input  logic             sub_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [WIDTH-1:0] S_o,
  output logic             C_o,
  output logic             ovf_o,
  output logic             valid_o,
  input  logic             ready_i
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] a_q, b_q, acc_q, acc_next;
  logic             carry_q;
  logic [CHUNK-1:0] a_chunk, b_chunk;
  logic [CHUNK:0]   chunk_sum;
  logic             accept, last, msb_carry_in;
  logic [WIDTH-1:0] s_q;
  logic             c_q, ovf_q;
  int unsigned      base;

  assign accept  = valid_i && (state == IDLE);
  assign last    = (k == KW'(NCHUNK - 1));
  assign ready_o = (state == IDLE);
  assign valid_o = (state == DONE);
  assign S_o     = s_q;
  assign C_o     = c_q;
  assign ovf_o   = ovf_q;

  // Add the current chunk and merge it into the partial sum.
  always_comb begin
    // NOTE: every signal gets a value before any branch, so no latch can be inferred.
    base      = int'(k) * CHUNK;
    a_chunk   = a_q[base +: CHUNK];
    b_chunk   = b_q[base +: CHUNK];
    chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
    acc_next  = acc_q;
    acc_next[base +: CHUNK] = chunk_sum[CHUNK-1:0];
    // Sum bit = a ^ b ^ carry-in, so the carry into the MSB falls out without
    // a separate partial adder, and works for CHUNK=1 too.
    msb_carry_in = acc_next[WIDTH-1] ^ a_q[WIDTH-1] ^ b_q[WIDTH-1];
  end

  // Next-state decode: IDLE -> CALC -> DONE -> IDLE.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (valid_i) state_next = CALC;
      CALC:    if (last)    state_next = DONE;
      DONE:    if (ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n_i) state <= IDLE;
    else          state <= state_next;
  end

  // Operand and partial-sum datapath.
  // NOTE: these registers carry no reset; each is written at accept or during CALC before it is read.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      a_q     <= A_i;
      b_q     <= sub_i ? ~B_i : B_i;
      carry_q <= sub_i ? ~C_i : C_i;
      k       <= '0;
    end else if (state == CALC) begin
      acc_q   <= acc_next;
      carry_q <= chunk_sum[CHUNK];
      k       <= k + 1'b1;
    end
  end

  // Result registers: loaded on the final chunk, held until the next one.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s_q   <= '0;
      c_q   <= 1'b0;
      ovf_q <= 1'b0;
    end else if (state == CALC && last) begin
      s_q   <= acc_next;
      c_q   <= chunk_sum[CHUNK];
      ovf_q <= msb_carry_in ^ chunk_sum[CHUNK];
    end
  end

endmodule
